// File: rtl/pipe_pkg.sv
// Shared constants for the RV32 pipeline sequencer: bubble encoding, FSM states, stage record.
package pipe_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  // opcode[6:2] values already decoded by the hazard logic
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;

  typedef struct packed {
    logic        vld;
    logic [31:0] instr;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '{vld: 1'b0, instr: NOP};

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: count advances one per cycle with inc high, sticks at all-ones.
// Registered output, one cycle from inc to count; no backpressure.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_ctrl.sv
// RV32 5-stage sequencer: owns D/X/M/W instruction registers, applies stall/flush/freeze, boot and halt/drain.
// Stage registers update one cycle after inputs; dmem_busy freezes everything, stall_F_D holds F/D and bubbles X.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int          BOOT_CYCLES = 4,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      f_instr,
  input  logic             f_valid,
  input  logic             stall_F_D,
  input  logic             redirect,
  input  logic             dmem_busy,
  input  logic             halt_req,
  input  logic             resume,
  output logic             fetch_en,
  output logic [31:0]      D_stage_instr,
  output logic [31:0]      X_stage_instr,
  output logic [31:0]      M_stage_instr,
  output logic [31:0]      W_stage_instr,
  output logic             D_valid,
  output logic             X_valid,
  output logic             M_valid,
  output logic             W_valid,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int             BW        = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BW-1:0]  BOOT_LAST = BW'((BOOT_CYCLES > 0) ? BOOT_CYCLES - 1 : 0);
  localparam state_t         RST_STATE = (BOOT_CYCLES == 0) ? ST_RUN : ST_BOOT;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [BW-1:0] r_boot_cnt;
  logic [BW-1:0] w_boot_nxt;
  logic          r_halt_pend;
  logic          w_halt_pend_nxt;
  logic          w_fetch_en;

  stage_t r_d, r_x, r_m, r_w;
  stage_t w_d_in;
  logic   w_active;
  logic   w_advance;
  logic   w_all_empty;
  logic   w_stall_inc;
  logic   w_flush_inc;

  assign w_active    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_advance   = w_active && !dmem_busy;
  assign w_all_empty = !(r_d.vld || r_x.vld || r_m.vld || r_w.vld);
  assign w_flush_inc = w_advance && redirect;
  assign w_stall_inc = w_advance && !redirect && stall_F_D;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RST_STATE;
      r_boot_cnt  <= '0;
      r_halt_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_boot_cnt  <= w_boot_nxt;
      r_halt_pend <= w_halt_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_boot_nxt      = r_boot_cnt;
    w_halt_pend_nxt = r_halt_pend;
    w_fetch_en      = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_boot_nxt = r_boot_cnt + 1'b1;
        if (halt_req) w_halt_pend_nxt = 1'b1;
        if (r_boot_cnt == BOOT_LAST) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // a halt latched during boot blocks fetch on the very first RUN cycle
        w_fetch_en = !(dmem_busy || stall_F_D || r_halt_pend);
        if (halt_req || r_halt_pend) begin
          w_state_nxt     = ST_DRAIN;
          w_halt_pend_nxt = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (w_all_empty) w_state_nxt = ST_HALTED;
      end
      ST_HALTED: begin
        if (resume) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = RST_STATE;
    endcase
  end

  // D only takes f_instr on cycles where fetch is actually consuming it
  assign w_d_in = (w_fetch_en && f_valid) ? '{vld: 1'b1, instr: f_instr} : STAGE_BUBBLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d <= STAGE_BUBBLE;
      r_x <= STAGE_BUBBLE;
      r_m <= STAGE_BUBBLE;
      r_w <= STAGE_BUBBLE;
    end else if (!w_active) begin
      r_d <= STAGE_BUBBLE;
      r_x <= STAGE_BUBBLE;
      r_m <= STAGE_BUBBLE;
      r_w <= STAGE_BUBBLE;
    end else if (w_advance) begin
      r_w <= r_m;
      r_m <= r_x;
      if (redirect) begin
        r_x <= STAGE_BUBBLE;
        r_d <= STAGE_BUBBLE;
      end else if (stall_F_D) begin
        r_x <= STAGE_BUBBLE;
      end else begin
        r_x <= r_d;
        r_d <= w_d_in;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_flush_inc),
    .count (flush_cnt)
  );

  assign fetch_en      = w_fetch_en;
  assign halted        = (r_state == ST_HALTED);
  assign D_stage_instr = r_d.instr;
  assign X_stage_instr = r_x.instr;
  assign M_stage_instr = r_m.instr;
  assign W_stage_instr = r_w.instr;
  assign D_valid       = r_d.vld;
  assign X_valid       = r_x.vld;
  assign M_valid       = r_m.vld;
  assign W_valid       = r_w.vld;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: boot, flow, stall, redirect, freeze, halt/resume, async reset, saturation.
module tb_pipe_ctrl;

  localparam logic [31:0] NOPI = 32'h0000_0013;
  localparam logic [31:0] I1 = 32'h0010_0093, I2 = 32'h0020_0113, I3 = 32'h0030_8193;
  localparam logic [31:0] IADD = 32'h0020_81b3, IBR = 32'h0020_8463, I5 = 32'h0050_0293;
  localparam logic [31:0] IA = 32'h00a0_0513, IB = 32'h00b0_0593, IJUNK = 32'hdead_beef;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] f_instr;
  logic        f_valid, stall_F_D, redirect, dmem_busy, halt_req, resume;
  logic        fetch_en, D_valid, X_valid, M_valid, W_valid, halted;
  logic [31:0] D_stage_instr, X_stage_instr, M_stage_instr, W_stage_instr;
  logic [15:0] stall_cnt, flush_cnt;
  logic        sat_inc;
  logic [1:0]  sat_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.BOOT_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .f_instr(f_instr), .f_valid(f_valid),
    .stall_F_D(stall_F_D), .redirect(redirect), .dmem_busy(dmem_busy),
    .halt_req(halt_req), .resume(resume), .fetch_en(fetch_en),
    .D_stage_instr(D_stage_instr), .X_stage_instr(X_stage_instr),
    .M_stage_instr(M_stage_instr), .W_stage_instr(W_stage_instr),
    .D_valid(D_valid), .X_valid(X_valid), .M_valid(M_valid), .W_valid(W_valid),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  sat_counter #(.W(2)) u_sat (.clk(clk), .rst_n(rst_n), .inc(sat_inc), .count(sat_count));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stages(input string tag, input logic [31:0] d, x, m, w);
    check_eq({tag, ".D"}, D_stage_instr, d);
    check_eq({tag, ".X"}, X_stage_instr, x);
    check_eq({tag, ".M"}, M_stage_instr, m);
    check_eq({tag, ".W"}, W_stage_instr, w);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; f_instr = '0; f_valid = 1'b0; stall_F_D = 1'b0; redirect = 1'b0;
    dmem_busy = 1'b0; halt_req = 1'b0; resume = 1'b0; sat_inc = 1'b0;
    #12;
    check_eq("rst.fetch_en", 32'(fetch_en), 32'd0);
    check_stages("rst", NOPI, NOPI, NOPI, NOPI);
    check_eq("rst.valids", 32'({D_valid, X_valid, M_valid, W_valid}), 32'd0);
    check_eq("rst.cnts", {stall_cnt, flush_cnt}, 32'd0);
    tick();
    rst_n = 1'b1;

    // BOOT: four cycles with fetch disabled and bubbles everywhere
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("boot%0d.fetch_en", i), 32'(fetch_en), 32'd0);
      check_eq($sformatf("boot%0d.D", i), D_stage_instr, NOPI);
      check_eq($sformatf("boot%0d.valids", i), 32'({D_valid, X_valid, M_valid, W_valid}), 32'd0);
      tick();
    end
    check_eq("run.fetch_en", 32'(fetch_en), 32'd1);

    // straight-line flow
    f_valid = 1'b1; f_instr = I1; tick();
    check_stages("flow1", I1, NOPI, NOPI, NOPI);
    f_instr = I2; tick();
    check_stages("flow2", I2, I1, NOPI, NOPI);
    f_instr = I3; tick();
    check_stages("flow3", I3, I2, I1, NOPI);
    f_valid = 1'b0; tick();
    check_stages("flow4", NOPI, I3, I2, I1);
    check_eq("flow4.valids", 32'({D_valid, X_valid, M_valid, W_valid}), 32'b0111);

    // two-cycle decode stall
    f_valid = 1'b1; f_instr = IADD; tick();
    check_eq("stall.pre.D", D_stage_instr, IADD);
    stall_F_D = 1'b1; f_instr = IBR; #1;
    check_eq("stall.fetch_en", 32'(fetch_en), 32'd0);
    tick();
    check_stages("stall1", IADD, NOPI, NOPI, I3);
    check_eq("stall1.cnt", 32'(stall_cnt), 32'd1);
    check_eq("stall1.fetch_en", 32'(fetch_en), 32'd0);
    tick();
    check_stages("stall2", IADD, NOPI, NOPI, NOPI);
    check_eq("stall2.cnt", 32'(stall_cnt), 32'd2);
    stall_F_D = 1'b0; #1;
    check_eq("stall.release.fetch_en", 32'(fetch_en), 32'd1);
    tick();
    check_stages("br.in", IBR, IADD, NOPI, NOPI);
    f_instr = I5; tick();
    check_stages("pre.redirect", I5, IBR, IADD, NOPI);

    // redirect with a simultaneous (ignored) stall
    redirect = 1'b1; stall_F_D = 1'b1; f_instr = IJUNK; tick();
    check_stages("redir", NOPI, NOPI, IBR, IADD);
    check_eq("redir.DXvld", 32'({D_valid, X_valid}), 32'd0);
    check_eq("redir.flush_cnt", 32'(flush_cnt), 32'd1);
    check_eq("redir.stall_cnt", 32'(stall_cnt), 32'd2);
    redirect = 1'b0; stall_F_D = 1'b0;

    // dmem freeze with a pending redirect
    f_instr = IA; tick();
    f_instr = IB; tick();
    check_stages("pre.freeze", IB, IA, NOPI, NOPI);
    dmem_busy = 1'b1; redirect = 1'b1; f_instr = IJUNK;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_stages($sformatf("freeze%0d", i), IB, IA, NOPI, NOPI);
      check_eq($sformatf("freeze%0d.cnts", i), {stall_cnt, flush_cnt}, {16'd2, 16'd1});
      check_eq($sformatf("freeze%0d.fetch_en", i), 32'(fetch_en), 32'd0);
    end
    dmem_busy = 1'b0; tick();
    check_stages("unfreeze", NOPI, NOPI, IA, NOPI);
    check_eq("unfreeze.flush_cnt", 32'(flush_cnt), 32'd2);
    redirect = 1'b0;

    // halt with three instructions in flight
    f_instr = I1; tick();
    f_instr = I2; tick();
    f_instr = I3; tick();
    check_eq("pre.halt.valids", 32'({D_valid, X_valid, M_valid, W_valid}), 32'b1110);
    halt_req = 1'b1; f_valid = 1'b0; tick();
    halt_req = 1'b0;
    check_eq("drain.fetch_en", 32'(fetch_en), 32'd0);
    check_eq("drain.W", W_stage_instr, I1);
    check_eq("drain.halted", 32'(halted), 32'd0);
    cyc = 0;
    while (!halted && cyc < 10) begin
      tick();
      cyc++;
    end
    check_eq("halt.latency", 32'(cyc), 32'd4);
    check_eq("halted", 32'(halted), 32'd1);
    halt_req = 1'b1; tick();
    check_eq("halted.ignore_halt", 32'(halted), 32'd1);
    check_eq("halted.D", D_stage_instr, NOPI);
    halt_req = 1'b0; resume = 1'b1; tick();
    resume = 1'b0;
    check_eq("resume.halted", 32'(halted), 32'd0);
    check_eq("resume.fetch_en", 32'(fetch_en), 32'd1);

    // reset in the middle of a drain
    f_valid = 1'b1; f_instr = I1; tick();
    halt_req = 1'b1; f_valid = 1'b0; tick();
    halt_req = 1'b0;
    check_eq("middrain.X", X_stage_instr, I1);
    check_eq("middrain.Xvld", 32'(X_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_stages("arst", NOPI, NOPI, NOPI, NOPI);
    check_eq("arst.valids", 32'({D_valid, X_valid, M_valid, W_valid}), 32'd0);
    check_eq("arst.cnts", {stall_cnt, flush_cnt}, 32'd0);
    check_eq("arst.fetch_en", 32'(fetch_en), 32'd0);
    check_eq("arst.halted", 32'(halted), 32'd0);
    tick();
    rst_n = 1'b1;

    // saturation on a narrow counter
    sat_inc = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    sat_inc = 1'b0;
    check_eq("sat.count", 32'(sat_count), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Sequencer for the 5-stage RV32 pipeline: owns the D/X/M/W instruction registers and valid bits, and gates fetch.
- Applies the decode hazard stall (`stall_F_D`), branch/jump redirect flushes and data-memory wait freezes.
- Inserts NOP bubbles so downstream hazard logic always sees legal instructions.
- Also sequences boot, halt/drain and resume, and keeps saturating stall/flush event counters.

Parameters:
- BOOT_CYCLES, 4, cycles after reset release before fetch is enabled (imem warm-up); 0 means enter RUN immediately.
- CNT_W, 16, width of the performance counters.
- NOP, 32'h00000013, bubble encoding (`addi x0,x0,0`); no destination, no rs2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- f_instr  in  32  instruction from fetch
- f_valid  in  1  f_instr valid this cycle
- stall_F_D  in  1  decode hazard stall (hold F and D, bubble X)
- redirect  in  1  taken branch/jump resolved in X
- dmem_busy  in  1  M-stage memory not ready (freeze all stages)
- halt_req  in  1  request to stop fetching and drain
- resume  in  1  leave HALTED
- fetch_en  out  1  fetch PC may advance
- D_stage_instr, X_stage_instr, M_stage_instr, W_stage_instr  out  32 each  stage instruction registers
- D_valid, X_valid, M_valid, W_valid  out  1 each  stage holds a real instruction
- halted  out  1  state == HALTED
- stall_cnt  out  CNT_W  cycles with stall_F_D applied
- flush_cnt  out  CNT_W  redirects applied

Behaviour:
- Reset (async, rst_n=0):
  - all stage instr = NOP, all valid = 0, fetch_en = 0, counters = 0.
  - state = BOOT and boot counter = 0, or RUN directly if BOOT_CYCLES == 0.
- FSM states: BOOT, RUN, DRAIN, HALTED.
  - BOOT: count to BOOT_CYCLES-1, then go to RUN. fetch_en = 0.
  - RUN: fetch_en = !(dmem_busy | stall_F_D). If halt_req, go to DRAIN.
  - DRAIN: fetch_en = 0; D is filled with NOP/valid 0; stages keep advancing. Go to HALTED once D_valid, X_valid, M_valid and W_valid are all 0.
  - HALTED: all stage registers hold NOP. If resume, go to RUN. halt_req is ignored in HALTED.
  - halt_req in BOOT is latched and honoured on entry to RUN.
- Per-cycle priority, highest first, evaluated in RUN and DRAIN:
  1. dmem_busy: every stage register and valid bit holds; counters do not increment; redirect and stall_F_D are ignored this cycle. The source holds them until dmem_busy drops.
  2. redirect: W<=M, M<=X, X<=NOP (valid 0), D<=NOP (valid 0). f_instr is discarded. flush_cnt += 1. stall_F_D is ignored, because the stalled D instruction is squashed anyway.
  3. stall_F_D: W<=M, M<=X, X<=NOP (valid 0), D holds. stall_cnt += 1.
  4. Otherwise: W<=M, M<=X, X<=D, D<=f_instr with D_valid = f_valid. If f_valid=0, D<=NOP.
- The W stage retires every cycle that dmem_busy=0; nothing is held beyond W.
- Counters saturate at all-ones (no wrap).
- Outputs are registered. The stage registers feed the decode hazard unit combinationally, with zero added latency.
- Reset asserted mid-operation: immediate asynchronous return to the reset values. In-flight instructions are lost, by design.

Decomposition:
- Shared package `pipe_pkg`:
  - NOP encoding;
  - FSM state encoding (BOOT=2'd0, RUN=2'd1, DRAIN=2'd2, HALTED=2'd3);
  - opcode constants already used by the hazard logic (LOAD 5'b00000, STORE 5'b01000, BRANCH 5'b11000, OP 5'b01100, LUI 5'b01101).
- One sub-module: `sat_counter` (parameter W; inc, clk, rst_n → count), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Reset, BOOT_CYCLES=4 → fetch_en=0 for exactly 4 cycles after rst_n rises, then 1. All instr = 32'h00000013 and valid = 0 throughout BOOT.
- Feed 0x00100093, 0x00200113, 0x00308193 with f_valid=1 and no hazards → each appears in D, X, M, W on consecutive cycles; W shows 0x00100093 four cycles after it was presented.
- Pulse stall_F_D for 2 cycles while D=0x002081b3 → D holds 0x002081b3, X=NOP twice, stall_cnt=2, fetch_en=0 for those cycles.
- redirect while D=0x00500293 and X=branch 0x00208463 → next cycle M=0x00208463, X=NOP, D=NOP, flush_cnt=1. Assert stall_F_D on the same cycle as well → it is ignored and stall_cnt is unchanged.
- dmem_busy for 3 cycles with redirect also held → all stages frozen and both counters unchanged during the freeze; the flush is applied on the first cycle dmem_busy=0.
- halt_req with 3 valid instructions in flight → DRAIN, halted=1 after they retire (≤4 cycles). resume → RUN and fetch_en=1 next cycle. Assert rst_n=0 mid-DRAIN → immediate return to the reset values.
